// File: rtl/bram_read_collector.sv
// Realigns BRAM read data to the fetch latency, tags tile-final beats and buffers them for the loader.
// Optional beat-count check against the latched tile length: define BRAM_COLLECT_LEN_CHECK_EN.
module bram_read_collector #(
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  bram_en,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    input  logic                  fetch_done,
    input  logic                  tiles_control,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  fetch_allow,
    output logic                  tile_done,
    output logic                  overflow,
    output logic                  len_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int THR_SHORT = 32;
    localparam int THR_LONG = (FIFO_DEPTH < 512) ? FIFO_DEPTH : 512;
    localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    logic [RD_LATENCY-1:0] en_pipe_q, en_pipe_d, done_pipe_q, done_pipe_d;
    logic                  cap_valid, cap_done;
    logic [9:0]            beat_cnt_q, beat_cnt_d;
    logic                  len32_q, len32_d, len32_cur, beat_last;
    state_t                state_q, state_d;
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d, cnt_after_pop;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  fetch_allow_q, fetch_allow_d;
    logic                  overflow_q, overflow_d;
    logic                  pop, full, push, drop;

    // Read-latency delay line shared by the read strobe and the tile-end pulse
    always_comb begin
        en_pipe_d   = '0;
        done_pipe_d = '0;
        en_pipe_d[0]   = bram_en;
        done_pipe_d[0] = fetch_done;
        for (int i = 1; i < RD_LATENCY; i++) begin
            en_pipe_d[i]   = en_pipe_q[i-1];
            done_pipe_d[i] = done_pipe_q[i-1];
        end
        if (clear) begin
            en_pipe_d   = '0;
            done_pipe_d = '0;
        end
    end

    assign cap_valid = en_pipe_q[RD_LATENCY-1];
    assign cap_done  = done_pipe_q[RD_LATENCY-1];
    assign len32_cur = (beat_cnt_q == '0) ? tiles_control : len32_q;
    assign beat_last = (beat_cnt_q == (len32_cur ? 10'd31 : 10'd511));

`ifdef BRAM_COLLECT_LEN_CHECK_EN
    logic len_err_q, len_err_d;
    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len32_d    = len32_q;
`ifdef BRAM_COLLECT_LEN_CHECK_EN
        len_err_d  = len_err_q;
`endif
        if (cap_valid) begin
            if (beat_cnt_q == '0) len32_d = tiles_control;
            beat_cnt_d = beat_last ? 10'd0 : beat_cnt_q + 10'd1;
        end
`ifdef BRAM_COLLECT_LEN_CHECK_EN
        // A completed tile has already wrapped the counter to zero
        if (cap_done && state_q == COLLECT) begin
            if (beat_cnt_d != '0) len_err_d = 1'b1;
            beat_cnt_d = '0;
        end
`endif
        if (clear) begin
            beat_cnt_d = '0;
`ifdef BRAM_COLLECT_LEN_CHECK_EN
            len_err_d  = 1'b0;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_valid) state_d = COLLECT;
            COLLECT: if (cap_done) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_comb begin
        tile_done = (state_q == DRAIN);
    end

    assign pop  = out_valid_q & out_ready;
    assign full = (count_q == FULL_CNT);
    assign push = cap_valid & ~clear & (~full | pop);
    assign drop = cap_valid & ~clear & full & ~pop;

    always_comb begin
        wr_ptr_d      = wr_ptr_q + {{(AW-1){1'b0}}, push};
        rd_ptr_d      = rd_ptr_q + {{(AW-1){1'b0}}, pop};
        cnt_after_pop = count_q - {{AW{1'b0}}, pop};
        count_d       = cnt_after_pop + {{AW{1'b0}}, push};
        out_valid_d   = (count_d != '0);
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        // Head register: a push into an otherwise empty buffer bypasses storage
        if (count_d != '0) begin
            if (push && cnt_after_pop == '0) {out_last_d, out_data_d} = {beat_last, bram_dout};
            else                              {out_last_d, out_data_d} = mem[rd_ptr_d];
        end
        overflow_d    = overflow_q | drop;
        fetch_allow_d = (FIFO_DEPTH - int'(count_q)) >= (tiles_control ? THR_SHORT : THR_LONG);
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            out_last_d  = out_last_q;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {beat_last, bram_dout};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_pipe_q     <= '0;
            done_pipe_q   <= '0;
            beat_cnt_q    <= '0;
            len32_q       <= 1'b0;
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            fetch_allow_q <= 1'b1;
            overflow_q    <= 1'b0;
`ifdef BRAM_COLLECT_LEN_CHECK_EN
            len_err_q     <= 1'b0;
`endif
        end else begin
            en_pipe_q     <= en_pipe_d;
            done_pipe_q   <= done_pipe_d;
            beat_cnt_q    <= beat_cnt_d;
            len32_q       <= len32_d;
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            fetch_allow_q <= fetch_allow_d;
            overflow_q    <= overflow_d;
`ifdef BRAM_COLLECT_LEN_CHECK_EN
            len_err_q     <= len_err_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign fetch_allow = fetch_allow_q;
    assign overflow    = overflow_q;
endmodule
